// File: rtl/hlsm_start_responder_if.sv
// Start/Done handshake bundle between an HLSM job source and hlsm_start_responder.
interface hlsm_start_responder_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUM_OPS   = 8
);
  logic                           Start;
  logic [NUM_OPS*DATAWIDTH-1:0]   OpIn;
  logic [NUM_OPS*DATAWIDTH-1:0]   OpHold;
  logic [DATAWIDTH-1:0]           FuncResult;
  logic                           Done;
  logic [DATAWIDTH-1:0]           Result;
  logic                           Busy;
  logic [15:0]                    JobCount;

  modport master (
    output Start, OpIn, FuncResult,
    input  OpHold, Done, Result, Busy, JobCount
  );

  modport slave (
    input  Start, OpIn, FuncResult,
    output OpHold, Done, Result, Busy, JobCount
  );
endinterface

// File: rtl/hlsm_start_responder.sv
// Start/Done control shell for scheduled HLSM datapaths: latch operands, wait LATENCY, register result.
// Optional build macro HLSM_RESP_RESTART_EN: Start during RUN restarts the job with fresh operands.
module hlsm_start_responder #(
  parameter int unsigned LATENCY   = 13,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUM_OPS   = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hlsm_start_responder_if.slave bus
);

  localparam int unsigned OPW = NUM_OPS * DATAWIDTH;
  localparam int unsigned CW  = 8;
  localparam int unsigned JW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [OPW-1:0]       ophold, ophold_nxt;
  logic [DATAWIDTH-1:0] result, result_nxt;
  logic [JW-1:0]        job_count_q, job_count_nxt;
  logic                 done_q, busy_q;

  // Next-state and datapath-capture decisions
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ophold_nxt    = ophold;
    result_nxt    = result;
    job_count_nxt = job_count_q;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt  = RUN;
          cnt_nxt    = CW'(1);
          ophold_nxt = bus.OpIn;
        end
      end
      RUN: begin
`ifdef HLSM_RESP_RESTART_EN
        if (bus.Start) begin
          cnt_nxt    = CW'(1);
          ophold_nxt = bus.OpIn;
        end else
`endif
        if (cnt == CW'(LATENCY)) begin
          state_nxt     = DONE;
          result_nxt    = bus.FuncResult;
          job_count_nxt = job_count_q + JW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_nxt  = RUN;
          cnt_nxt    = CW'(1);
          ophold_nxt = bus.OpIn;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs; Done/Busy are decoded from the next state so they are flops
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ophold      <= '0;
      result      <= '0;
      job_count_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ophold      <= ophold_nxt;
      result      <= result_nxt;
      job_count_q <= job_count_nxt;
      done_q      <= (state_nxt == DONE);
      busy_q      <= (state_nxt == RUN);
    end
  end

  assign bus.OpHold   = ophold;
  assign bus.Result   = result;
  assign bus.JobCount = job_count_q;
  assign bus.Done     = done_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_hlsm_start_responder.sv
// Self-checking bench for hlsm_start_responder: timestamp-based job model plus directed scenarios.
module tb_hlsm_start_responder;

  localparam int unsigned DW   = 32;
  localparam int unsigned NOPS = 8;
  localparam int unsigned OPW  = DW * NOPS;

  typedef struct {
    int             lat;
    int             edge_n;
    bit             active;
    int             due;
    logic [OPW-1:0] held;
    logic           done;
    logic [DW-1:0]  result;
    logic [15:0]    jobs;
  } model_t;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  hlsm_start_responder_if #(.DATAWIDTH(DW), .NUM_OPS(NOPS)) bus13 ();
  hlsm_start_responder_if #(.DATAWIDTH(DW), .NUM_OPS(NOPS)) bus2  ();

  hlsm_start_responder #(.LATENCY(13), .DATAWIDTH(DW), .NUM_OPS(NOPS)) dut13 (
    .Clk(Clk), .Rst(Rst), .bus(bus13.slave));
  hlsm_start_responder #(.LATENCY(2), .DATAWIDTH(DW), .NUM_OPS(NOPS)) dut2 (
    .Clk(Clk), .Rst(Rst), .bus(bus2.slave));

  // External datapath: sum of the first two held operands
  assign bus13.FuncResult = bus13.OpHold[DW-1:0] + bus13.OpHold[2*DW-1:DW];
  assign bus2.FuncResult  = bus2.OpHold[DW-1:0]  + bus2.OpHold[2*DW-1:DW];

  int     total = 0;
  int     bad   = 0;
  int     ecnt  = 0;
  bit     chk_en = 1'b0;
  bit     preload = 1'b0;
  model_t m13, m2;

  task automatic chk(input string nm, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", nm, got, exp, ecnt);
    end
  endtask

  function automatic logic [DW-1:0] func(input logic [OPW-1:0] h);
    return h[DW-1:0] + h[2*DW-1:DW];
  endfunction

  // Job model: each job is an accept time plus a due time; no counter or state encoding
  task automatic mstep(inout model_t m, input logic rst, input logic start, input logic [OPW-1:0] opin);
    bit fin, acc;
    m.edge_n++;
    if (rst) begin
      m.active = 1'b0; m.done = 1'b0; m.held = '0; m.result = '0; m.jobs = '0;
      return;
    end
    fin = m.active && (m.edge_n == m.due);
`ifdef HLSM_RESP_RESTART_EN
    acc = start;
`else
    acc = start && !m.active;
`endif
    m.done = 1'b0;
    if (acc) begin
      m.held   = opin;
      m.active = 1'b1;
      m.due    = m.edge_n + m.lat;
    end else if (fin) begin
      m.done   = 1'b1;
      m.result = func(m.held);
      m.jobs   = m.jobs + 16'd1;
      m.active = 1'b0;
    end
  endtask

  initial begin
    m13 = '{lat: 13, edge_n: 0, active: 1'b0, due: 0, held: '0, done: 1'b0, result: '0, jobs: '0};
    m2  = '{lat: 2,  edge_n: 0, active: 1'b0, due: 0, held: '0, done: 1'b0, result: '0, jobs: '0};
  end

  always @(posedge Clk) begin
    ecnt++;
    if (preload) m13.jobs = 16'hFFFF;
    mstep(m13, Rst, bus13.Start, bus13.OpIn);
    mstep(m2,  Rst, bus2.Start,  bus2.OpIn);
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("d13_done",   OPW'(bus13.Done),     OPW'(m13.done));
      chk("d13_busy",   OPW'(bus13.Busy),     OPW'(m13.active));
      chk("d13_result", OPW'(bus13.Result),   OPW'(m13.result));
      chk("d13_jobs",   OPW'(bus13.JobCount), OPW'(m13.jobs));
      chk("d13_ophold", bus13.OpHold,         m13.held);
      chk("d2_done",    OPW'(bus2.Done),      OPW'(m2.done));
      chk("d2_busy",    OPW'(bus2.Busy),      OPW'(m2.active));
      chk("d2_result",  OPW'(bus2.Result),    OPW'(m2.result));
      chk("d2_jobs",    OPW'(bus2.JobCount),  OPW'(m2.jobs));
      chk("d2_ophold",  bus2.OpHold,          m2.held);
    end
  end

  function automatic logic [OPW-1:0] pack_ops(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [OPW-1:0] v;
    for (int i = 0; i < int'(NOPS); i++) v[i*DW +: DW] = DW'($urandom);
    v[DW-1:0]    = a;
    v[2*DW-1:DW] = b;
    return v;
  endfunction

  task automatic wait_done13(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      if (bus13.Done === 1'b1) begin
        at = ecnt;
        break;
      end
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL d13_done_timeout: no Done within %0d cycles", limit);
    end
  endtask

  task automatic pulse13(input logic [DW-1:0] a, input logic [DW-1:0] b, output int acc_edge);
    bus13.OpIn  = pack_ops(a, b);
    bus13.Start = 1'b1;
    acc_edge    = ecnt + 1;
    @(negedge Clk);
    bus13.Start = 1'b0;
  endtask

  int k, at, k2;

  initial begin
    Rst = 1'b1;
    bus13.Start = 1'b0; bus13.OpIn = '0;
    bus2.Start  = 1'b0; bus2.OpIn  = '0;

    // Reset held for 10 cycles with Start toggling and busy operands
    @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus13.Start = ~bus13.Start;
      bus2.Start  = ~bus2.Start;
      bus13.OpIn  = pack_ops(DW'(i + 1), DW'(i + 2));
      bus2.OpIn   = pack_ops(DW'(i + 3), DW'(i + 4));
      @(negedge Clk);
    end
    bus13.Start = 1'b0; bus2.Start = 1'b0;
    Rst = 1'b0;
    chk("rst_busy",   OPW'(bus13.Busy), '0);
    chk("rst_jobs",   OPW'(bus13.JobCount), '0);
    chk("rst_ophold", bus13.OpHold, '0);
    @(negedge Clk);

    // Single job: 5 + 10, Done exactly 13 edges after accept
    pulse13(32'd5, 32'd10, k);
    wait_done13(40, at);
    chk("single_latency", OPW'(at - k), OPW'(13));
    chk("single_result",  OPW'(bus13.Result), OPW'(32'd15));
    chk("single_jobs",    OPW'(bus13.JobCount), OPW'(16'd1));
    chk("single_busy_in_done", OPW'(bus13.Busy), '0);
    repeat (3) @(negedge Clk);

    // Second Start five edges into a running job
    pulse13(32'd7, 32'd8, k);
    repeat (4) @(negedge Clk);
    pulse13(32'd100, 32'd200, k2);
    wait_done13(40, at);
`ifdef HLSM_RESP_RESTART_EN
    chk("restart_latency", OPW'(at - k), OPW'(18));
    chk("restart_result",  OPW'(bus13.Result), OPW'(32'd300));
`else
    chk("ignore_latency", OPW'(at - k), OPW'(13));
    chk("ignore_result",  OPW'(bus13.Result), OPW'(32'd15));
`endif
    chk("second_start_jobs", OPW'(bus13.JobCount), OPW'(16'd2));
    repeat (25) @(negedge Clk);
    chk("second_start_single_done", OPW'(bus13.JobCount), OPW'(16'd2));

    // Back-to-back on LATENCY=2: Done every 3 edges
    bus2.OpIn  = pack_ops(32'd1, 32'd2);
    bus2.Start = 1'b1;
    repeat (12) @(negedge Clk);
    chk("b2b_done_4th", OPW'(bus2.Done), OPW'(1'b1));
    chk("b2b_jobs",     OPW'(bus2.JobCount), OPW'(16'd4));
    chk("b2b_result",   OPW'(bus2.Result), OPW'(32'd3));
    bus2.Start = 1'b0;
    repeat (5) @(negedge Clk);

    // Reset six edges into a job: no Done, counters cleared
    pulse13(32'd9, 32'd9, k);
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    chk("midrst_result", OPW'(bus13.Result), '0);
    chk("midrst_jobs",   OPW'(bus13.JobCount), '0);

    // Completion counter wrap from 0xFFFF
    preload = 1'b1;
    @(posedge Clk);
    #1;
    force dut13.job_count_q = 16'hFFFF;
    #1;
    release dut13.job_count_q;
    preload = 1'b0;
    @(negedge Clk);
    chk("wrap_preload", OPW'(bus13.JobCount), OPW'(16'hFFFF));
    pulse13(32'd3, 32'd4, k);
    wait_done13(40, at);
    chk("wrap_jobs",   OPW'(bus13.JobCount), OPW'(16'h0000));
    chk("wrap_result", OPW'(bus13.Result), OPW'(32'd7));
    repeat (3) @(negedge Clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
